ifu_lockstep_cmp: RTL and testbench

//  Checker end of the redundant-core IFU path. Receives the main core's IFU output packet and delays it DELAY cycles.

---
 rtl/ifu_lockstep_cmp.sv | 152 +++++++++++++++
 tb/tb_ifu_lockstep_cmp.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_lockstep_cmp.sv
// Checker end of the redundant-core IFU path: delays the main-core packet by DELAY
// cycles, compares it with the lagging shadow packet and records miscompares.
module ifu_lockstep_cmp #(
   parameter int DELAY    = 2,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmp_en,
   input  logic                clr_err,
   input  logic [79:0]         main_pkt,
   input  logic [79:0]         shd_pkt,
   output logic                mismatch,
   output logic                err_sticky,
   output logic [ERRCNT_W-1:0] err_cnt,
   output logic [31:0]         first_err_pc,
   output logic [79:0]         first_err_diff,
   output logic [1:0]          cmp_state
);

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
      logic        pc_vld;
      logic        misalgn;
      logic        buserr;
      logic [4:0]  rs1idx;
      logic [4:0]  rs2idx;
      logic        prdt_taken;
      logic        muldiv_b2b;
      logic        valid;
   } ifu_pkt_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_CHECK = 2'd2
   } cmp_state_e;

   localparam logic [1:0]          FILL_LAST = 2'(DELAY - 1);
   localparam logic [ERRCNT_W-1:0] CNT_MAX   = '1;
   localparam logic [ERRCNT_W-1:0] CNT_ONE   = ERRCNT_W'(1);

   if (DELAY < 1 || DELAY > 4) begin : g_bad_delay
      $error("ifu_lockstep_cmp: DELAY must be in 1..4");
   end

   logic [79:0]         dline_q [DELAY];
   cmp_state_e          state_q;
   logic [1:0]          fill_cnt_q;
   logic                mismatch_q;
   logic                sticky_q;
   logic [ERRCNT_W-1:0] cnt_q;
   logic [31:0]         cap_pc_q;
   logic [79:0]         cap_diff_q;

   ifu_pkt_t dmain;
   ifu_pkt_t shd;
   ifu_pkt_t cmp_mask;
   logic [79:0] diff;
   logic        miscmp;

   // NOTE: the delay line is reset like any other register so a fresh run never
   // starts from X data; its width is small enough that this costs nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DELAY; i++) dline_q[i] <= '0;
      end else begin
         dline_q[0] <= main_pkt;
         for (int i = 1; i < DELAY; i++) dline_q[i] <= dline_q[i-1];
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      dmain           = ifu_pkt_t'(dline_q[DELAY-1]);
      shd             = ifu_pkt_t'(shd_pkt);
      cmp_mask        = '0;
      cmp_mask.pc     = '1;
      cmp_mask.pc_vld = 1'b1;
      cmp_mask.valid  = 1'b1;
      if (dmain.valid) cmp_mask = '1;
      diff   = (dmain ^ shd) & cmp_mask;
      miscmp = (state_q == ST_CHECK) && (|diff);
   end

   // Dropping cmp_en returns to IDLE from any state; a CHECK-cycle compare still counts.
   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fill_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmp_en) begin
                  state_q    <= ST_FILL;
                  fill_cnt_q <= '0;
               end
            end
            ST_FILL: begin
               if (!cmp_en) begin
                  state_q <= ST_IDLE;
               end else begin
                  fill_cnt_q <= fill_cnt_q + 2'd1;
                  if (fill_cnt_q == FILL_LAST) state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!cmp_en) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // A miscompare wins over a simultaneous clear and restarts the record with itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_q <= 1'b0;
         sticky_q   <= 1'b0;
         cnt_q      <= '0;
         cap_pc_q   <= '0;
         cap_diff_q <= '0;
      end else begin
         mismatch_q <= miscmp;
         if (miscmp) begin
            sticky_q <= 1'b1;
            if (clr_err)             cnt_q <= CNT_ONE;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
            if (!sticky_q || clr_err) begin
               cap_pc_q   <= dmain.pc;
               cap_diff_q <= diff;
            end
         end else if (clr_err) begin
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
            cap_pc_q   <= '0;
            cap_diff_q <= '0;
         end
      end
   end

   assign mismatch       = mismatch_q;
   assign err_sticky     = sticky_q;
   assign err_cnt        = cnt_q;
   assign first_err_pc   = cap_pc_q;
   assign first_err_diff = cap_diff_q;
   assign cmp_state      = state_q;

endmodule

// File: tb/tb_ifu_lockstep_cmp.sv
// Randomised self-checking bench for ifu_lockstep_cmp against a history-based
// reference model of the lockstep checker.
module tb_ifu_lockstep_cmp;
   localparam int DELAY    = 2;
   localparam int ERRCNT_W = 8;
   localparam int CNT_MAX  = (1 << ERRCNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                cmp_en = 1'b0;
   logic                clr_err = 1'b0;
   logic [79:0]         main_pkt = '0;
   logic [79:0]         shd_pkt = '0;
   logic                mismatch;
   logic                err_sticky;
   logic [ERRCNT_W-1:0] err_cnt;
   logic [31:0]         first_err_pc;
   logic [79:0]         first_err_diff;
   logic [1:0]          cmp_state;

   always #5 clk = ~clk;

   ifu_lockstep_cmp #(.DELAY(DELAY), .ERRCNT_W(ERRCNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cmp_en(cmp_en), .clr_err(clr_err),
      .main_pkt(main_pkt), .shd_pkt(shd_pkt), .mismatch(mismatch),
      .err_sticky(err_sticky), .err_cnt(err_cnt), .first_err_pc(first_err_pc),
      .first_err_diff(first_err_diff), .cmp_state(cmp_state)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: main-packet history plus the run length of cmp_en.
   logic [79:0] hist[$];
   int          run;
   logic        m_mis;
   logic        m_sticky;
   int          m_cnt;
   logic [31:0] m_pc;
   logic [79:0] m_diff;

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < DELAY; i++) hist.push_back('0);
      run = 0; m_mis = 0; m_sticky = 0; m_cnt = 0; m_pc = '0; m_diff = '0;
   endfunction

   // Comparing needs DELAY+1 consecutive enabled cycles since the last IDLE.
   function automatic logic [1:0] exp_state();
      if (run == 0) return 2'd0;
      if (run <= DELAY) return 2'd1;
      return 2'd2;
   endfunction

   function automatic logic [79:0] masked_diff(input logic [79:0] d, input logic [79:0] s);
      logic [79:0] x;
      x = d ^ s;
      if (d[0] == 1'b0) begin
         x[79:48] = '0;
         x[14:1]  = '0;
      end
      return x;
   endfunction

   function automatic logic [79:0] rnd_pkt();
      return {$urandom(), $urandom(), 16'($urandom())};
   endfunction

   function automatic logic [79:0] mk(input logic [31:0] ir, input logic [31:0] pc, input logic vld);
      logic [79:0] p;
      p = rnd_pkt();
      p[79:48] = ir;
      p[47:16] = pc;
      p[0]     = vld;
      return p;
   endfunction

   function automatic logic [79:0] pc_flip();
      logic [79:0] x;
      x = '0;
      x[16 + int'($urandom_range(31, 0))] = 1'b1;
      return x;
   endfunction

   // One clock: shd_pkt is the delayed main packet XOR sx.
   task automatic cycle(input logic [79:0] mp, input logic [79:0] sx, input logic en, input logic clr);
      logic [79:0] dm;
      logic [79:0] dff;
      logic        mis;
      dm       = hist[0];
      main_pkt = mp;
      shd_pkt  = dm ^ sx;
      cmp_en   = en;
      clr_err  = clr;
      dff = masked_diff(dm, dm ^ sx);
      mis = (exp_state() == 2'd2) && (dff != '0);
      m_mis = mis;
      if (mis) begin
         if (!m_sticky || clr) begin
            m_pc   = dm[47:16];
            m_diff = dff;
         end
         m_cnt    = clr ? 1 : (m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX);
         m_sticky = 1'b1;
      end else if (clr) begin
         m_sticky = 0; m_cnt = 0; m_pc = '0; m_diff = '0;
      end
      run = en ? (run < 1000 ? run + 1 : run) : 0;
      hist.push_back(mp);
      void'(hist.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      #12;
      n_vec++;
      if ({mismatch, err_sticky, err_cnt, first_err_pc, first_err_diff, cmp_state} !== '0) begin
         n_bad++;
         $display("FAIL reset_values: got mis=%b st=%b cnt=%0d pc=%h diff=%h state=%0d, want all 0",
                  mismatch, err_sticky, err_cnt, first_err_pc, first_err_diff, cmp_state);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(rnd_pkt(), '0, 1'b0, 1'b0);
      n_vec++;
      if (cmp_state !== 2'd0) begin
         n_bad++;
         $display("FAIL idle_hold: got state=%0d want 0", cmp_state);
      end
   endtask

   task automatic test_fill();
      for (int k = 1; k <= DELAY + 4; k++) begin
         cycle(rnd_pkt(), '0, 1'b1, 1'b0);
         n_vec++;
         if (cmp_state !== ((k <= DELAY) ? 2'd1 : 2'd2) || mismatch !== 1'b0 ||
             err_cnt !== '0 || err_sticky !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_seq k=%0d: got state=%0d mis=%b cnt=%0d st=%b want state=%0d mis=0 cnt=0 st=0",
                     k, cmp_state, mismatch, err_cnt, err_sticky, (k <= DELAY) ? 1 : 2);
         end
      end
   endtask

   task automatic test_ir_diff();
      logic [31:0] exp_pc;
      for (int i = 0; i < DELAY; i++) cycle(mk(32'h0000_0013, 32'h8000_0000 + 32'(4 * i), 1'b1), '0, 1'b1, 1'b0);
      exp_pc = hist[0][47:16];
      cycle(mk(32'h0000_0013, 32'h8000_0100, 1'b1), {32'h0010_0080, 48'h0}, 1'b1, 1'b0);
      n_vec++;
      if (mismatch !== 1'b1 || err_cnt !== 8'd1 || err_sticky !== 1'b1) begin
         n_bad++;
         $display("FAIL ir_diff_flags: got mis=%b cnt=%0d st=%b want 1 1 1", mismatch, err_cnt, err_sticky);
      end
      n_vec++;
      if (first_err_diff !== {32'h0010_0080, 48'h0} || first_err_pc !== exp_pc) begin
         n_bad++;
         $display("FAIL ir_diff_capture: got pc=%h diff=%h want pc=%h diff=%h",
                  first_err_pc, first_err_diff, exp_pc, {32'h0010_0080, 48'h0});
      end
      cycle(mk(32'h0000_0013, 32'h8000_0104, 1'b1), '0, 1'b1, 1'b0);
      n_vec++;
      if (mismatch !== 1'b0 || err_cnt !== 8'd1 || err_sticky !== 1'b1) begin
         n_bad++;
         $display("FAIL ir_diff_pulse: got mis=%b cnt=%0d st=%b want 0 1 1", mismatch, err_cnt, err_sticky);
      end
   endtask

   task automatic test_masked();
      cycle(rnd_pkt(), '0, 1'b1, 1'b1);
      for (int i = 0; i < DELAY + 1; i++) cycle(mk(32'h0000_0013, 32'h4000_0000 + 32'(4 * i), 1'b0), '0, 1'b1, 1'b0);
      cycle(mk(32'h0000_0013, 32'h4000_0100, 1'b0), {32'h0010_0080, 48'h0}, 1'b1, 1'b0);
      n_vec++;
      if (mismatch !== 1'b0 || err_sticky !== 1'b0) begin
         n_bad++;
         $display("FAIL masked_ir: got mis=%b st=%b want 0 0", mismatch, err_sticky);
      end
      cycle(mk(32'h0000_0013, 32'h4000_0104, 1'b0), {32'h0, 32'h1, 16'h0}, 1'b1, 1'b0);
      n_vec++;
      if (mismatch !== 1'b1 || first_err_diff !== {32'h0, 32'h1, 16'h0}) begin
         n_bad++;
         $display("FAIL pc_diff_invalid: got mis=%b diff=%h want 1 %h", mismatch, first_err_diff, {32'h0, 32'h1, 16'h0});
      end
   endtask

   task automatic test_saturate();
      logic [31:0] first_pc;
      cycle(rnd_pkt(), '0, 1'b1, 1'b1);
      first_pc = hist[0][47:16];
      for (int i = 0; i < 300; i++) begin
         cycle(rnd_pkt(), pc_flip(), 1'b1, 1'b0);
         n_vec++;
         if (mismatch !== m_mis || err_cnt !== ERRCNT_W'(m_cnt) || err_sticky !== m_sticky ||
             first_err_pc !== m_pc || first_err_diff !== m_diff) begin
            n_bad++;
            $display("FAIL sat_step i=%0d: got mis=%b cnt=%0d st=%b pc=%h diff=%h want %b %0d %b %h %h",
                     i, mismatch, err_cnt, err_sticky, first_err_pc, first_err_diff,
                     m_mis, m_cnt, m_sticky, m_pc, m_diff);
         end
      end
      n_vec++;
      if (err_cnt !== 8'd255 || err_sticky !== 1'b1 || first_err_pc !== first_pc) begin
         n_bad++;
         $display("FAIL sat_final: got cnt=%0d st=%b pc=%h want 255 1 %h", err_cnt, err_sticky, first_err_pc, first_pc);
      end
   endtask

   task automatic test_clr_with_err();
      logic [31:0] exp_pc;
      exp_pc = hist[0][47:16];
      cycle(rnd_pkt(), pc_flip(), 1'b1, 1'b1);
      n_vec++;
      if (mismatch !== 1'b1 || err_cnt !== 8'd1 || err_sticky !== 1'b1 || first_err_pc !== exp_pc) begin
         n_bad++;
         $display("FAIL clr_with_err: got mis=%b cnt=%0d st=%b pc=%h want 1 1 1 %h",
                  mismatch, err_cnt, err_sticky, first_err_pc, exp_pc);
      end
   endtask

   task automatic test_clr_alone();
      cycle(rnd_pkt(), '0, 1'b1, 1'b1);
      n_vec++;
      if ({mismatch, err_sticky, err_cnt, first_err_pc, first_err_diff} !== '0 || cmp_state !== 2'd2) begin
         n_bad++;
         $display("FAIL clr_alone: got mis=%b st=%b cnt=%0d pc=%h diff=%h state=%0d want all 0, state 2",
                  mismatch, err_sticky, err_cnt, first_err_pc, first_err_diff, cmp_state);
      end
   endtask

   // Re-arm from IDLE with a shadow stream that always differs: no compare until FILL ends.
   task automatic rearm_check(input string tag);
      for (int k = 1; k <= DELAY + 2; k++) begin
         cycle(rnd_pkt(), pc_flip(), 1'b1, 1'b0);
         n_vec++;
         if (cmp_state !== ((k <= DELAY) ? 2'd1 : 2'd2) || mismatch !== (k >= DELAY + 2) || mismatch !== m_mis) begin
            n_bad++;
            $display("FAIL %s k=%0d: got state=%0d mis=%b want state=%0d mis=%b",
                     tag, k, cmp_state, mismatch, (k <= DELAY) ? 1 : 2, k >= DELAY + 2);
         end
      end
   endtask

   task automatic test_async_reset();
      cycle(rnd_pkt(), pc_flip(), 1'b1, 1'b0);
      cycle(rnd_pkt(), pc_flip(), 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({mismatch, err_sticky, err_cnt, first_err_pc, first_err_diff, cmp_state} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: got mis=%b st=%b cnt=%0d pc=%h diff=%h state=%0d want all 0",
                  mismatch, err_sticky, err_cnt, first_err_pc, first_err_diff, cmp_state);
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      rearm_check("reset_refill");
   endtask

   task automatic test_en_drop();
      cycle(rnd_pkt(), pc_flip(), 1'b0, 1'b0);
      n_vec++;
      if (cmp_state !== 2'd0 || mismatch !== 1'b1) begin
         n_bad++;
         $display("FAIL drop_in_check: got state=%0d mis=%b want 0 1", cmp_state, mismatch);
      end
      cycle(rnd_pkt(), '0, 1'b1, 1'b0);
      cycle(rnd_pkt(), pc_flip(), 1'b0, 1'b0);
      n_vec++;
      if (cmp_state !== 2'd0 || mismatch !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_in_fill: got state=%0d mis=%b want 0 0", cmp_state, mismatch);
      end
      rearm_check("fill_restart");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle(rnd_pkt(), ($urandom_range(2, 0) == 0) ? rnd_pkt() : 80'h0,
               $urandom_range(9, 0) != 0, $urandom_range(15, 0) == 0);
         n_vec++;
         if (mismatch !== m_mis || err_cnt !== ERRCNT_W'(m_cnt) || err_sticky !== m_sticky ||
             first_err_pc !== m_pc || first_err_diff !== m_diff || cmp_state !== exp_state()) begin
            n_bad++;
            $display("FAIL random i=%0d: got mis=%b cnt=%0d st=%b pc=%h diff=%h state=%0d want %b %0d %b %h %h %0d",
                     i, mismatch, err_cnt, err_sticky, first_err_pc, first_err_diff, cmp_state,
                     m_mis, m_cnt, m_sticky, m_pc, m_diff, exp_state());
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_ir_diff();
      test_masked();
      test_saturate();
      test_clr_with_err();
      test_clr_alone();
      test_async_reset();
      test_en_drop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
